// File: rtl/ixc_sv_gfifo_mc.sv
// Multi-channel gated FIFO: CHANNELS independent FIFOs drained round-robin onto one
// valid/ready port, with a 64-bit read counter and periodic/watermark timestamp requests.
module ixc_sv_gfifo_mc #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int TS_INTERVAL = 256,
  parameter int HWM         = DEPTH - 2,
  localparam int AW  = $clog2(DEPTH),
  localparam int PW  = AW + 1,
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TSW = $clog2(TS_INTERVAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [CHANNELS-1:0]    wr_valid,
  output logic [CHANNELS-1:0]    wr_ready,
  input  logic [CHANNELS*WIDTH-1:0] wr_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [CW-1:0]          rd_chan,
  output logic [63:0]            rd_cnt,
  output logic                   ts_req,
  output logic [CHANNELS*PW-1:0] occ,
  output logic                   arbState
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Once rd_valid is raised it stays high with rd_data/rd_chan stable until accepted
  // (or until flush/rst); wr_ready depends only on registered state.

  typedef enum logic {ARB_IDLE = 1'b0, ARB_HOLD = 1'b1} arbStateT;

  localparam logic [PW-1:0] HWM_LVL = PW'(HWM);
  localparam logic [PW-1:0] HWM_PRE = PW'(HWM - 1);

  logic [WIDTH-1:0] mem [CHANNELS][DEPTH];
  logic [PW-1:0]    wrPtr [CHANNELS];
  logic [PW-1:0]    rdPtr [CHANNELS];
  logic [PW-1:0]    occCur [CHANNELS];
  logic [PW-1:0]    occNext [CHANNELS];

  logic [CHANNELS-1:0] isFull;
  logic [CHANNELS-1:0] isEmpty;
  logic [CHANNELS-1:0] push;
  logic [CHANNELS-1:0] popCh;
  logic [CHANNELS-1:0] hwmCross;

  arbStateT       arbSt;
  logic [CW-1:0]  grantReg;
  logic [CW-1:0]  rrPtr;
  logic [CW-1:0]  arbSel;
  logic [CW-1:0]  grant;
  logic [CW-1:0]  idxSel;
  logic           arbFound;
  logic           pop;
  logic [63:0]    cntNext;
  logic           tsPeriodic;
  int             idx;

  // Per-channel status, write acceptance and occupancy bookkeeping.
  always_comb begin
    occ = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      isEmpty[c]  = (wrPtr[c] == rdPtr[c]);
      isFull[c]   = (wrPtr[c][AW] != rdPtr[c][AW]) &&
                    (wrPtr[c][AW-1:0] == rdPtr[c][AW-1:0]);
      wr_ready[c] = ~isFull[c];
      push[c]     = wr_valid[c] & ~isFull[c] & ~flush;
      popCh[c]    = pop && (grant == CW'(c));
      occCur[c]   = wrPtr[c] - rdPtr[c];
      occNext[c]  = occCur[c] + PW'(push[c]) - PW'(popCh[c]);
      hwmCross[c] = (occCur[c] == HWM_PRE) && (occNext[c] == HWM_LVL);
      occ[c*PW +: PW] = occCur[c];
    end
  end

  // Round-robin search from rrPtr upward, wrapping at CHANNELS.
  always_comb begin
    arbSel   = '0;
    arbFound = 1'b0;
    idx      = 0;
    idxSel   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(rrPtr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      idxSel = CW'(idx);
      if (!arbFound && !isEmpty[idxSel]) begin
        arbFound = 1'b1;
        arbSel   = idxSel;
      end
    end
  end

  // In HOLD the latched grant wins; otherwise the live search result is presented,
  // which gives single-cycle latency from write to rd_valid without a wr->rd path.
  always_comb begin
    grant      = (arbSt == ARB_HOLD) ? grantReg : arbSel;
    rd_valid   = (arbSt == ARB_HOLD) | arbFound;
    pop        = rd_valid & rd_ready & ~flush;
    rd_chan    = rd_valid ? grant : '0;
    rd_data    = rd_valid ? mem[grant][rdPtr[grant][AW-1:0]] : '0;
    cntNext    = rd_cnt + 64'd1;
    tsPeriodic = pop && (cntNext[TSW-1:0] == '0);
  end

  assign arbState = arbSt;

  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!rst && push[c]) mem[c][wrPtr[c][AW-1:0]] <= wr_data[c*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wrPtr[c] <= '0;
        rdPtr[c] <= '0;
      end
      rd_cnt   <= '0;
      ts_req   <= 1'b0;
      arbSt    <= ARB_IDLE;
      grantReg <= '0;
      rrPtr    <= '0;
    end else begin
      // push/pop are already masked by flush, so a flush can never raise ts_req.
      ts_req <= tsPeriodic | (|hwmCross);
      if (flush) begin
        for (int c = 0; c < CHANNELS; c++) rdPtr[c] <= wrPtr[c];
        arbSt    <= ARB_IDLE;
        grantReg <= '0;
      end else begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (push[c])  wrPtr[c] <= wrPtr[c] + 1'b1;
          if (popCh[c]) rdPtr[c] <= rdPtr[c] + 1'b1;
        end
        if (pop) begin
          rd_cnt <= cntNext;
          rrPtr  <= (grant == CW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
          arbSt  <= ARB_IDLE;
        end else if (rd_valid) begin
          arbSt    <= ARB_HOLD;
          grantReg <= grant;
        end
      end
    end
  end

endmodule
